// File: rtl/spi_frame_pkg.sv
// SPI frame layout shared by the master and the slave register banks:
// slot positions, frame sizes, master FSM encoding and the frame builder.
package spi_frame_pkg;

    localparam int unsigned FRAME_BITS    = 16;
    localparam int unsigned FRAME_SLOTS   = 17;

    localparam int unsigned WR_SLOT       = 0;
    localparam int unsigned EXT_LSB       = 1;
    localparam int unsigned RSV_SLOT      = 4;
    localparam int unsigned REG_LSB       = 5;
    localparam int unsigned DATA_LSB      = 8;

    localparam int unsigned CAPTURE_FIRST = 9;
    localparam int unsigned CAPTURE_LAST  = 16;

    typedef enum logic [1:0] {
        StGap  = 2'd0,
        StIdle = 2'd1,
        StXfer = 2'd2
    } state_e;

    // Bit n of the result is the value shown in frame slot n.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic       wr,
        input logic [2:0] ext_addr,
        input logic [2:0] reg_addr,
        input logic       rsv,
        input logic [7:0] wdata
    );
        logic [FRAME_BITS-1:0] f;
        f                 = '0;
        f[WR_SLOT]        = wr;
        f[EXT_LSB +: 3]   = ext_addr;
        f[RSV_SLOT]       = rsv;
        f[REG_LSB +: 3]   = reg_addr;
        f[DATA_LSB +: 8]  = wdata;
        return f;
    endfunction

endpackage

// File: rtl/spi_master_ctrl.sv
// SPI frame master: serialises one 16-bit request frame over 17 slots and
// captures the 8-bit reply plus the slave response flag.
module spi_master_ctrl
    import spi_frame_pkg::*;
#(
    parameter logic        RESERVED_BIT = 1'b0,
    parameter int unsigned IDLE_GAP     = 1
) (
    input  logic       i_sclk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_wr,
    input  logic [2:0] i_ext_addr,
    input  logic [2:0] i_reg_addr,
    input  logic [7:0] i_wdata,
    input  logic       i_miso,
    input  logic       i_miso_oe,
    output logic       o_ready,
    output logic       o_cs,
    output logic       o_mosi,
    output logic       o_done,
    output logic [7:0] o_rdata,
    output logic       o_ack
);

    localparam logic [3:0] GapLast  = 4'(IDLE_GAP - 1);
    localparam logic [4:0] SlotLast = 5'(FRAME_SLOTS - 1);
    localparam logic [4:0] CapFirst = 5'(CAPTURE_FIRST);
    localparam logic [4:0] CapLast  = 5'(CAPTURE_LAST);

    state_e                r_state, w_state_d;
    logic [4:0]            r_slot, w_slot_d;
    logic [3:0]            r_gap, w_gap_d;
    logic [FRAME_BITS-1:0] r_tx, w_tx_d;
    logic [7:0]            r_rx, w_rx_d;
    logic                  r_ackacc, w_ackacc_d;
    logic                  r_cs, w_cs_d;
    logic                  r_mosi, w_mosi_d;
    logic                  r_done, w_done_d;
    logic [7:0]            r_rdata, w_rdata_d;
    logic                  r_ack, w_ack_d;
    logic                  r_ready, w_ready_d;
    logic [FRAME_BITS-1:0] w_frame;
    logic [7:0]            w_rx_shift;

    assign w_frame    = build_frame(i_wr, i_ext_addr, i_reg_addr, RESERVED_BIT, i_wdata);
    assign w_rx_shift = {i_miso, r_rx[7:1]};

    always_comb begin
        w_state_d  = r_state;
        w_slot_d   = r_slot;
        w_gap_d    = r_gap;
        w_tx_d     = r_tx;
        w_rx_d     = r_rx;
        w_ackacc_d = r_ackacc;
        w_cs_d     = r_cs;
        w_mosi_d   = 1'b0;
        w_done_d   = 1'b0;
        w_rdata_d  = r_rdata;
        w_ack_d    = r_ack;
        unique case (r_state)
            StGap: begin
                w_cs_d = 1'b0;
                if (r_gap == GapLast) begin
                    w_gap_d   = '0;
                    w_state_d = StIdle;
                end else begin
                    w_gap_d = r_gap + 4'd1;
                end
            end
            StIdle: begin
                if (i_start) begin
                    w_mosi_d   = w_frame[WR_SLOT];
                    w_tx_d     = w_frame >> 1;
                    w_cs_d     = 1'b1;
                    w_slot_d   = '0;
                    w_rx_d     = '0;
                    w_ackacc_d = 1'b1;
                    w_state_d  = StXfer;
                end
            end
            StXfer: begin
                // The tx register drains to zero, so the realign slot shows 0.
                w_mosi_d = r_tx[0];
                w_tx_d   = r_tx >> 1;
                if (r_slot >= CapFirst && r_slot <= CapLast) begin
                    w_rx_d     = w_rx_shift;
                    w_ackacc_d = r_ackacc & i_miso_oe;
                end
                if (r_slot == SlotLast) begin
                    w_cs_d    = 1'b0;
                    w_done_d  = 1'b1;
                    w_rdata_d = w_rx_shift;
                    w_ack_d   = r_ackacc & i_miso_oe;
                    w_gap_d   = '0;
                    w_state_d = StGap;
                end else begin
                    w_slot_d = r_slot + 5'd1;
                end
            end
            default: begin
                w_cs_d    = 1'b0;
                w_gap_d   = '0;
                w_state_d = StGap;
            end
        endcase
        w_ready_d = (w_state_d == StIdle);
    end

    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            r_state  <= StGap;
            r_slot   <= '0;
            r_gap    <= '0;
            r_tx     <= '0;
            r_rx     <= '0;
            r_ackacc <= 1'b0;
            r_cs     <= 1'b0;
            r_mosi   <= 1'b0;
            r_done   <= 1'b0;
            r_rdata  <= '0;
            r_ack    <= 1'b0;
            r_ready  <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_slot   <= w_slot_d;
            r_gap    <= w_gap_d;
            r_tx     <= w_tx_d;
            r_rx     <= w_rx_d;
            r_ackacc <= w_ackacc_d;
            r_cs     <= w_cs_d;
            r_mosi   <= w_mosi_d;
            r_done   <= w_done_d;
            r_rdata  <= w_rdata_d;
            r_ack    <= w_ack_d;
            r_ready  <= w_ready_d;
        end
    end

    assign o_ready = r_ready;
    assign o_cs    = r_cs;
    assign o_mosi  = r_mosi;
    assign o_done  = r_done;
    assign o_rdata = r_rdata;
    assign o_ack   = r_ack;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (default parameters and IDLE_GAP=4 with
// RESERVED_BIT=1) share stimulus; a frame-timeline model predicts every output each cycle.
module tb_spi_master_ctrl;

    logic       clk;
    logic       rst, start, wr;
    logic       miso    = 1'b0;
    logic       miso_oe = 1'b0;
    logic [2:0] ext_addr, reg_addr;
    logic [7:0] wdata;

    logic [1:0]      d_ready, d_cs, d_mosi, d_done, d_ack;
    logic [1:0][7:0] d_rdata;

    int n_chk = 0;
    int n_err = 0;
    int e_now = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    spi_master_ctrl #(.RESERVED_BIT(1'b0), .IDLE_GAP(1)) u_dut0 (
        .i_sclk(clk), .i_rst(rst), .i_start(start), .i_wr(wr), .i_ext_addr(ext_addr),
        .i_reg_addr(reg_addr), .i_wdata(wdata), .i_miso(miso), .i_miso_oe(miso_oe),
        .o_ready(d_ready[0]), .o_cs(d_cs[0]), .o_mosi(d_mosi[0]), .o_done(d_done[0]),
        .o_rdata(d_rdata[0]), .o_ack(d_ack[0])
    );

    spi_master_ctrl #(.RESERVED_BIT(1'b1), .IDLE_GAP(4)) u_dut1 (
        .i_sclk(clk), .i_rst(rst), .i_start(start), .i_wr(wr), .i_ext_addr(ext_addr),
        .i_reg_addr(reg_addr), .i_wdata(wdata), .i_miso(miso), .i_miso_oe(miso_oe),
        .o_ready(d_ready[1]), .o_cs(d_cs[1]), .o_mosi(d_mosi[1]), .o_done(d_done[1]),
        .o_rdata(d_rdata[1]), .o_ack(d_ack[1])
    );

    // Model state: per instance, the acceptance edge of the frame in flight and the
    // edge after which ready is expected to be high again.
    bit          m_inf[2];
    int          m_acc[2];
    int          m_rdy_at[2];
    logic [16:0] m_k[2];
    logic [7:0]  m_samp[2];
    logic        m_oeall[2];
    logic        exp_cs[2], exp_mosi[2], exp_done[2], exp_ready[2], exp_ack[2];
    logic [7:0]  exp_rdata[2];
    bit          model_valid = 1'b0;

    logic [7:0]  resp_byte;
    logic        resp_oe;

    logic [15:0] cap[2];
    int          pos[2];
    int          low_run[2];
    int          last_low[2];
    logic        prev_cs[2];
    int          rise_q0[$];
    int          rise_q1[$];

    function automatic int gap_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic logic rsv_of(input int i);
        return (i == 0) ? 1'b0 : 1'b1;
    endfunction

    task automatic chk(input string name, input int inst, input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d edge %0d: got %0h expected %0h", name, inst, e_now, act, exp);
        end
    endtask

    // Predict the outputs right after edge e from the inputs present before it.
    task automatic model_step(input int i, input int e);
        int j;
        if (rst) begin
            m_inf[i]     = 1'b0;
            m_rdy_at[i]  = e + gap_of(i);
            exp_cs[i]    = 1'b0;
            exp_mosi[i]  = 1'b0;
            exp_done[i]  = 1'b0;
            exp_rdata[i] = 8'h00;
            exp_ack[i]   = 1'b0;
            exp_ready[i] = 1'b0;
            return;
        end
        exp_done[i] = 1'b0;
        exp_cs[i]   = 1'b0;
        exp_mosi[i] = 1'b0;
        if (m_inf[i]) begin
            j = e - m_acc[i];
            if (j >= 10) begin
                m_samp[i][j-10] = miso;
                m_oeall[i]      = m_oeall[i] & miso_oe;
            end
            if (j <= 16) begin
                exp_cs[i]   = 1'b1;
                exp_mosi[i] = m_k[i][j];
            end else begin
                exp_done[i]  = 1'b1;
                exp_rdata[i] = m_samp[i];
                exp_ack[i]   = m_oeall[i];
                m_inf[i]     = 1'b0;
                m_rdy_at[i]  = e + gap_of(i);
            end
        end else if (start && exp_ready[i]) begin
            m_inf[i]   = 1'b1;
            m_acc[i]   = e;
            m_oeall[i] = 1'b1;
            m_k[i]     = '0;
            m_k[i][0]  = wr;
            for (int b = 0; b < 3; b++) m_k[i][1+b] = ext_addr[b];
            m_k[i][4]  = rsv_of(i);
            for (int b = 0; b < 3; b++) m_k[i][5+b] = reg_addr[b];
            for (int b = 0; b < 8; b++) m_k[i][8+b] = wdata[b];
            exp_cs[i]   = 1'b1;
            exp_mosi[i] = m_k[i][0];
        end
        exp_ready[i] = !m_inf[i] && (e >= m_rdy_at[i]);
    endtask

    // Compare, observe, play the slave, then advance the model to the next edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (model_valid) begin
                    chk("cs",    i, 16'(d_cs[i]),    16'(exp_cs[i]));
                    chk("mosi",  i, 16'(d_mosi[i]),  16'(exp_mosi[i]));
                    chk("done",  i, 16'(d_done[i]),  16'(exp_done[i]));
                    chk("ready", i, 16'(d_ready[i]), 16'(exp_ready[i]));
                    chk("rdata", i, 16'(d_rdata[i]), 16'(exp_rdata[i]));
                    chk("ack",   i, 16'(d_ack[i]),   16'(exp_ack[i]));
                end
                if (d_cs[i] === 1'b1 && prev_cs[i] !== 1'b1) begin
                    pos[i]      = 0;
                    last_low[i] = low_run[i];
                    low_run[i]  = 0;
                    if (i == 0) rise_q0.push_back(e_now);
                    else        rise_q1.push_back(e_now);
                end else if (d_cs[i] === 1'b1) begin
                    pos[i]++;
                end else begin
                    low_run[i]++;
                end
                if (d_cs[i] === 1'b1 && pos[i] < 16) cap[i][pos[i]] = d_mosi[i];
                prev_cs[i] = d_cs[i];
            end
            e_now++;
            if (m_inf[0] && (e_now - m_acc[0]) >= 10 && (e_now - m_acc[0]) <= 17) begin
                miso    = resp_byte[e_now - m_acc[0] - 10];
                miso_oe = resp_oe;
            end else begin
                miso    = 1'b0;
                miso_oe = 1'b0;
            end
            for (int i = 0; i < 2; i++) model_step(i, e_now);
            if (rst) model_valid = 1'b1;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!(d_ready[0] === 1'b1 && d_ready[1] === 1'b1) && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("ready_wait", -1, 16'(n < 100), 16'd1);
    endtask

    task automatic issue(input logic w, input logic [2:0] ea, input logic [2:0] ra,
                         input logic [7:0] wd);
        wait_ready();
        wr       = w;
        ext_addr = ea;
        reg_addr = ra;
        wdata    = wd;
        start    = 1'b1;
        @(posedge clk);
        #2;
        start    = 1'b0;
        // Scramble the request inputs; the frame in flight must not follow them.
        wr       = ~w;
        ext_addr = ~ea;
        reg_addr = ~ra;
        wdata    = ~wd;
        repeat (20) @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        wr        = 1'b0;
        ext_addr  = 3'd0;
        reg_addr  = 3'd0;
        wdata     = 8'h00;
        resp_byte = 8'h00;
        resp_oe   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("rst_cs",    i, 16'(d_cs[i]),    16'd0);
            chk("rst_mosi",  i, 16'(d_mosi[i]),  16'd0);
            chk("rst_done",  i, 16'(d_done[i]),  16'd0);
            chk("rst_ready", i, 16'(d_ready[i]), 16'd0);
            chk("rst_rdata", i, 16'(d_rdata[i]), 16'd0);
            chk("rst_ack",   i, 16'(d_ack[i]),   16'd0);
        end

        // Write frame: k0..k15 = 1,1,0,1,0,0,1,0,1,0,1,0,0,1,0,1 (slot 4 = RESERVED_BIT).
        resp_byte = 8'h00;
        resp_oe   = 1'b1;
        issue(1'b1, 3'd5, 3'd2, 8'hA5);
        chk("wr_mosi_seq", 0, cap[0], 16'hA54B);
        chk("wr_mosi_seq", 1, cap[1], 16'hA55B);
        chk("wr_ack",      0, 16'(d_ack[0]), 16'd1);

        // Read frame with a responding slave.
        resp_byte = 8'h3C;
        resp_oe   = 1'b1;
        issue(1'b0, 3'd1, 3'd6, 8'h00);
        for (int i = 0; i < 2; i++) begin
            chk("rd_rdata", i, 16'(d_rdata[i]), 16'h003C);
            chk("rd_ack",   i, 16'(d_ack[i]),   16'd1);
        end

        // No responder: rdata is whatever was on miso, ack drops.
        resp_byte = 8'h96;
        resp_oe   = 1'b0;
        issue(1'b0, 3'd7, 3'd3, 8'h5A);
        chk("noresp_rdata", 0, 16'(d_rdata[0]), 16'h0096);
        chk("noresp_ack",   0, 16'(d_ack[0]),   16'd0);

        // Back-to-back: start held across three dut0 frames.
        resp_oe = 1'b1;
        wait_ready();
        rise_q0.delete();
        rise_q1.delete();
        wr       = 1'b1;
        ext_addr = 3'd2;
        reg_addr = 3'd4;
        wdata    = 8'hC3;
        start    = 1'b1;
        repeat (39) @(posedge clk);
        #2;
        start = 1'b0;
        repeat (25) @(posedge clk);
        #2;
        chk("b2b_count", 0, 16'(rise_q0.size()), 16'd3);
        chk("b2b_count", 1, 16'(rise_q1.size()), 16'd2);
        if (rise_q0.size() == 3) begin
            chk("b2b_period", 0, 16'(rise_q0[1] - rise_q0[0]), 16'd19);
            chk("b2b_period", 0, 16'(rise_q0[2] - rise_q0[1]), 16'd19);
        end
        if (rise_q1.size() == 2) chk("b2b_period", 1, 16'(rise_q1[1] - rise_q1[0]), 16'd22);
        // Low run counts the gap cycles plus the accepting idle cycle.
        chk("b2b_cs_low", 0, 16'(last_low[0]), 16'd2);
        chk("b2b_cs_low", 1, 16'(last_low[1]), 16'd5);

        // Reset while dut0 sits at slot 7.
        wait_ready();
        wr       = 1'b0;
        ext_addr = 3'd3;
        reg_addr = 3'd1;
        wdata    = 8'hFF;
        start    = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("midrst_cs",    i, 16'(d_cs[i]),    16'd0);
            chk("midrst_done",  i, 16'(d_done[i]),  16'd0);
            chk("midrst_ready", i, 16'(d_ready[i]), 16'd0);
        end
        repeat (25) @(posedge clk);
        #2;
        resp_oe = 1'b1;
        issue(1'b1, 3'd5, 3'd2, 8'hA5);
        chk("post_rst_mosi_seq", 0, cap[0], 16'hA54B);
        chk("post_rst_mosi_seq", 1, cap[1], 16'hA55B);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
